// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder/subtractor. One full-adder cell is reused across WIDTH
//   operand bits, one bit per clock, LSB first. Operands are captured on an
//   accepted start; a one-cycle done pulse marks the cycle in which the
//   result registers hold the new result.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, accepted only while busy = 0
//   sub    0: in0 + in1 + cin, 1: in0 - in1 (sampled with start)
//   cin    carry-in for add, ignored for subtract (sampled with start)
//   in0    operand A (sampled with start)
//   in1    operand B (sampled with start)
//   busy   high while bits are being processed
//   done   one-cycle pulse, results valid
//   out    sum/difference, held until the next completion
//   c_out  carry out of the MSB (subtract: 1 = no borrow)
//   ovf    signed overflow
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] out_reg;
  logic             c_out_reg;
  logic             ovf_reg;

  // Shared full-adder cell working on the current LSBs.
  logic             sum_bit;
  logic             carry_next;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] res_next;

  assign sum_bit    = a_reg[0] ^ b_reg[0] ^ carry_reg;
  assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
  assign last_bit   = (cnt_reg == CW'(WIDTH - 1));
  assign accept     = (state_reg != ST_RUN) && start;

  // Result fills from the top: after WIDTH shifts the first (LSB) sum bit
  // has travelled down to bit 0.
  assign res_next = {sum_bit, res_reg[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. DONE behaves like IDLE so a start in the done cycle
  // chains straight into the next operation.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      ST_RUN:           state_next = last_bit ? ST_DONE : ST_RUN;
      default:          state_next = ST_IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath. Subtraction is A + ~B + 1, so B is inverted on load and the
  // carry is preset to 1; cin only matters for addition.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      out_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= in0;
      b_reg     <= sub ? ~in1 : in1;
      carry_reg <= sub ? 1'b1 : cin;
      cnt_reg   <= '0;
    end else if (state_reg == ST_RUN) begin
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      carry_reg <= carry_next;
      res_reg   <= res_next;
      cnt_reg   <= cnt_reg + CW'(1);
      if (last_bit) begin
        out_reg   <= res_next;
        c_out_reg <= carry_next;
        // carry_reg still holds the carry into the MSB on this cycle.
        ovf_reg   <= carry_reg ^ carry_next;
      end
    end
  end

  assign out   = out_reg;
  assign c_out = c_out_reg;
  assign ovf   = ovf_reg;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor, the multi-bit successor to the single-bit full adder. It time-multiplexes one full-adder cell across `WIDTH` operand bits, processing one bit per clock, LSB first. Operands load on a start handshake, and a one-cycle `done` pulse marks valid results. It is the low-area arithmetic building block for the datapath stages that follow.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width in bits; legal range ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only when `busy`=0.
- `sub`  in  1  mode, sampled with `start`: 0 = in0+in1+cin, 1 = in0−in1.
- `cin`  in  1  carry-in, sampled with `start`; ignored when `sub`=1.
- `in0`  in  WIDTH  operand A, sampled with `start`.
- `in1`  in  WIDTH  operand B, sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; results valid.
- `out`  out  WIDTH  sum/difference; holds until the next completion.
- `c_out`  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- `ovf`  out  1  signed overflow, equal to carry-into-MSB XOR carry-out-of-MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE or DONE, `start`=1:**
  - Load A←in0.
  - Load B←(sub ? ~in1 : in1).
  - Load carry←(sub ? 1 : cin).
  - Clear bit counter to 0 and go to RUN.
- **IDLE or DONE, `start`=0:** go to or stay in IDLE.
- **RUN, each edge:**
  - s = A[0]^B[0]^carry.
  - carry ← majority(A[0],B[0],carry).
  - Shift s into the MSB of the internal result shift register.
  - Shift A and B right by 1.
  - Counter increments.
  - On the edge where the counter equals WIDTH−1, the cycle is the final bit:
    - copy the completed result to `out`;
    - set `c_out` to the final carry;
    - set `ovf` to the carry into bit WIDTH−1 XOR the final carry;
    - go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE, or RUN if `start`=1.
- `start` during RUN is ignored; no queueing.
- Arithmetic is modulo 2^WIDTH. Subtraction is two's complement: A + ~B + 1.
- `out`, `c_out` and `ovf` change only on the completion edge. They hold their previous values during RUN.

## Timing
- **Reset** (`rst`=1 at an edge): state=IDLE; `busy`=0, `done`=0, `out`=0, `c_out`=0, `ovf`=0; counter and internal registers 0. `rst` overrides `start`.
- **Reset mid-RUN:** aborts the operation; no `done`; outputs return to 0.
- **Latency:**
  - `start` is sampled at edge E0.
  - `busy`=1 from E0 through E_WIDTH.
  - `done`=1 and results are valid in the cycle after edge E_WIDTH.
  - Total: WIDTH edges after acceptance.
- **Throughput:** back-to-back `start` in the DONE cycle gives one result every WIDTH+1 cycles.
- **Sampling:** inputs are sampled only at the accept edge. Changing `in0`, `in1`, `sub` or `cin` during RUN has no effect.

## Test plan
All scenarios use WIDTH=8.
- **Simple add:** in0=0x01, in1=0x00, cin=0, sub=0, start for one cycle → `done` exactly 8 edges after the accept edge; out=0x01, c_out=0, ovf=0; busy high for 8 cycles.
- **Carry and overflow:**
  - 0xFF+0x01, cin=0 → out=0x00, c_out=1, ovf=0.
  - 0x7F+0x01 → out=0x80, c_out=0, ovf=1.
- **Subtract:**
  - sub=1, 0x05−0x07, cin=1 (ignored) → out=0xFE, c_out=0, ovf=0.
  - 0x80−0x01 → out=0x7F, c_out=1, ovf=1.
- **Stable inputs:** start pulse during RUN, and operands changed mid-RUN → result of the original operands only; a single `done`.
- **Back-to-back:** 0x01+0x01, cin=1, then start asserted in the DONE cycle with 0x10+0x20 → results 0x03, then 0x30; the second `done` comes 9 cycles after the first. `out` holds 0x03 throughout the second RUN.
- **Reset mid-operation:** assert `rst` on the 3rd RUN cycle → next cycle busy=0, out=0, c_out=0, no `done`; a subsequent 0x0A+0x05 yields 0x0F normally.
